// File: rtl/serdes_pkg.sv
// Shared definitions for the SERDES receive framer.
//   rx_state_t          : framer alignment state
//   SERDES_SYNC_DEFAULT : default sync byte that opens every frame
//   clog2               : width helper for the byte-slot counter
package serdes_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } rx_state_t;

    localparam logic [7:0] SERDES_SYNC_DEFAULT = 8'hA5;

    // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serdes_rx_framer.sv
// Receive-side frame aligner. Hunts for SYNC_WORD in the qualified serial
// stream, confirms alignment over LOCK_CNT sync slots, then emits payload
// bytes with a one-cycle strobe. LOSS_CNT consecutive bad sync slots drop lock.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   ser_in, ser_en      : serial bit (MSB first) and its qualifier
//   data_out            : last payload byte, held between strobes
//   data_valid, sof     : payload strobe, start-of-frame (payload byte 0)
//   locked              : state is SYNC
//   sync_err            : missed sync byte while locked
//
// state   | meaning
// HUNT    | bit-by-bit search for the sync byte
// PRESYNC | framing found, counting good sync slots, no output
// SYNC    | locked, payload emitted, misses tolerated up to LOSS_CNT
module serdes_rx_framer
    import serdes_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD     = SERDES_SYNC_DEFAULT,
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         LOCK_CNT      = 2,
    parameter int         LOSS_CNT      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    input  logic       ser_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sof,
    output logic       locked,
    output logic       sync_err
);

    localparam int              BCW       = clog2(PAYLOAD_BYTES + 1);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(PAYLOAD_BYTES);
    localparam logic [BCW-1:0]  FIRST_PL  = BCW'(1);
    localparam logic [2:0]      LOCK_N    = 3'(LOCK_CNT);
    localparam logic [2:0]      LOSS_N    = 3'(LOSS_CNT);

    rx_state_t      state_q, state_d;
    // Only the newest 7 bits are ever needed: the current byte is formed
    // by appending the incoming bit.
    logic [6:0]     sr_q, sr_d;
    logic [2:0]     bit_q, bit_d;
    logic [BCW-1:0] byte_q, byte_d;
    logic [3:0]     fill_q, fill_d;
    logic [2:0]     good_q, good_d;
    logic [2:0]     miss_q, miss_d;
    logic [7:0]     data_q, data_d;
    logic           dv_q, dv_d;
    logic           sof_q, sof_d;
    logic           err_q, err_d;
    logic [7:0]     cur_byte;

    assign cur_byte = {sr_q, ser_in};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        fill_d  = fill_q;
        good_d  = good_q;
        miss_d  = miss_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        sof_d   = 1'b0;
        err_d   = 1'b0;

        if (ser_en) begin
            sr_d = cur_byte[6:0];
            if (fill_q != 4'd8) begin
                fill_d = fill_q + 4'd1;
            end

            unique case (state_q)
                HUNT: begin
                    if (fill_q >= 4'd7 && cur_byte == SYNC_WORD) begin
                        state_d = PRESYNC;
                        good_d  = 3'd1;
                        bit_d   = 3'd0;
                        byte_d  = FIRST_PL;
                    end
                end
                PRESYNC, SYNC: begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (byte_q == '0) begin
                            byte_d = FIRST_PL;
                            if (cur_byte == SYNC_WORD) begin
                                if (state_q == PRESYNC) begin
                                    good_d = good_q + 3'd1;
                                    if (good_q + 3'd1 == LOCK_N) begin
                                        state_d = SYNC;
                                    end
                                end else begin
                                    miss_d = 3'd0;
                                end
                            end else if (state_q == PRESYNC) begin
                                state_d = HUNT;
                                bit_d   = 3'd0;
                                byte_d  = '0;
                                good_d  = 3'd0;
                                miss_d  = 3'd0;
                            end else begin
                                err_d  = 1'b1;
                                miss_d = miss_q + 3'd1;
                                if (miss_q + 3'd1 == LOSS_N) begin
                                    state_d = HUNT;
                                    bit_d   = 3'd0;
                                    byte_d  = '0;
                                    good_d  = 3'd0;
                                    miss_d  = 3'd0;
                                end
                            end
                        end else begin
                            byte_d = (byte_q == LAST_BYTE) ? '0 : byte_q + FIRST_PL;
                            if (state_q == SYNC) begin
                                data_d = cur_byte;
                                dv_d   = 1'b1;
                                sof_d  = (byte_q == FIRST_PL);
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            sr_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            fill_q  <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            sof_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            fill_q  <= fill_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            sof_q   <= sof_d;
            err_q   <= err_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign sof        = sof_q;
    assign sync_err   = err_q;
    assign locked     = (state_q == SYNC);

endmodule
